mac_tx_retry_ctrl: RTL and testbench
====================================

Name: mac_tx_retry_ctrl

Overview:
Half-duplex transmit retry controller for the Ethernet MAC. It sits beside the transmit replay buffer and watches collisions from the PHY/MAC. On a collision it sequences jam, truncated binary exponential backoff and packet replay. It ends the replay window with done on success, late collision or excessive collisions.

Parameters:
MAX_ATTEMPTS, 16, collisions per packet before the packet is dropped (802.3 attemptLimit)
BACKOFF_LIMIT, 10, maximum backoff exponent k
SLOT_CYCLES, 512, clk cycles per slot time
JAM_CYCLES, 32, clk cycles jam is held after a collision
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tx_start  in  1  pulse: first beat of a new packet presented to the MAC (ignored unless IDLE)
tx_end  in  1  pulse: MAC finished transmitting the frame (last beat and FCS sent)
collision  in  1  collision detected by the PHY (level, sampled every cycle)
replayable  in  1  replay buffer's replayable output
replay  out  1  pulse to the replay buffer's replay input
done  out  1  pulse to the replay buffer's done input
gate  out  1  high: MAC must not take handshakes from the buffer (jam/backoff)
jam  out  1  high: MAC transmits the jam pattern
drop  out  1  pulse: packet abandoned (excessive or late collision)
late_collision  out  1  pulse: collision seen while replayable low
attempts  out  5  collisions so far on the current packet

Behaviour:
- Reset: state IDLE; replay, done, gate, jam, drop and late_collision are 0; attempts is 0; LFSR is LFSR_SEED. Reset mid-packet aborts immediately, with no done or drop pulse.
- All outputs are registered. All pulses last exactly one cycle.
- States: IDLE, XMIT, JAM, BACKOFF.
- IDLE:
  - tx_start -> XMIT, with attempts cleared to 0.
  - collision and tx_end are ignored.
- XMIT:
  - collision with replayable=1 -> JAM; attempts += 1 (saturating at MAX_ATTEMPTS); abort flag cleared.
  - collision with replayable=0 -> JAM; late_collision pulses next cycle; abort flag set; attempts unchanged.
  - tx_end without collision -> done pulses next cycle -> IDLE.
  - collision and tx_end in the same cycle: collision wins.
- JAM:
  - jam=1 and gate=1 for exactly JAM_CYCLES cycles, counted from the cycle after the collision was sampled.
  - collision and tx_end are ignored.
  - On the final jam cycle, exit as follows:
    - If abort is set or attempts == MAX_ATTEMPTS: drop and done pulse together -> IDLE.
    - Else, if replayable=0 (defensive check): treat as late collision. late_collision, drop and done all pulse -> IDLE.
    - Else: replay pulses; capture r = lfsr[BACKOFF_LIMIT-1:0] & ((1<<k)-1), where k = min(attempts, BACKOFF_LIMIT) -> BACKOFF.
- BACKOFF:
  - gate=1, jam=0.
  - Waits r*SLOT_CYCLES cycles: a slot counter counts down r, and a cycle counter wraps at SLOT_CYCLES-1.
  - When r == 0, it stays exactly 1 cycle.
  - Then -> XMIT with gate=0. No new tx_start is needed; the buffer restarts from the first beat.
  - collision is ignored (carrier deference is the MAC's job).
- gate is high in JAM and BACKOFF, and low otherwise.
- Because gate holds the MAC off, no handshakes occur while gate is high. replayable therefore cannot fall during JAM/BACKOFF under legal MAC behaviour.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every clk cycle, never all-zero.
- Widths:
  - attempts is $clog2(MAX_ATTEMPTS+1) bits; it is the 5-bit port at the default and tracks MAX_ATTEMPTS.
  - Slot counter is BACKOFF_LIMIT bits; cycle counter is $clog2(SLOT_CYCLES) bits; jam counter is $clog2(JAM_CYCLES) bits.
- Compliance: replay is only ever driven while replayable=1. done is always driven when a packet leaves XMIT or JAM towards IDLE.

Decomposition:
- Shared package: state encoding (IDLE/XMIT/JAM/BACKOFF), default JAM_CYCLES, SLOT_CYCLES, MAX_ATTEMPTS and BACKOFF_LIMIT constants.
- One natural sub-module: lfsr16 (seeded Galois LFSR with enable). It is reusable by the other random backoff users.

Test Plan:
- No collision: tx_start, then tx_end 100 cycles later -> done pulse 1 cycle after tx_end; no replay, gate or jam; attempts stays 0.
- Single collision at cycle 20 of XMIT with replayable=1 -> jam high for 32 cycles; replay pulse on the last jam cycle; attempts=1; gate held 32 + r*512 cycles (at least 1 in BACKOFF) with r in {0,1}; return to XMIT; then tx_end -> done.
- Force r=0 via LFSR_SEED chosen so the low bit is 0 at the exit cycle -> BACKOFF lasts exactly 1 cycle, then XMIT.
- 16 consecutive collisions, each answered by the controller -> attempts reaches 16; 16th jam ends with drop+done, no replay; r never exceeds 1023 (k saturates at 10 from the 10th attempt on).
- Collision with replayable=0 -> late_collision pulse next cycle; jam for 32 cycles; then drop+done; attempts unchanged; no replay.
- rst asserted mid-BACKOFF -> all outputs 0 asynchronously; IDLE; the next tx_start behaves as fresh; collision together with tx_end in XMIT -> JAM, no done.

Source files
------------

// File: rtl/mac_tx_retry_ctrl_pkg.sv
// Shared types and default constants for the half-duplex transmit retry controller.
package mac_tx_retry_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXmit,
        StJam,
        StBackoff
    } tx_state_e;

    localparam int unsigned DefMaxAttempts  = 16;
    localparam int unsigned DefBackoffLimit = 10;
    localparam int unsigned DefSlotCycles   = 512;
    localparam int unsigned DefJamCycles    = 32;

    localparam logic [15:0] DefLfsrSeed = 16'hACE1;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] Lfsr16Taps  = 16'hB400;

endpackage

// File: rtl/mac_tx_retry_ctrl_lfsr16.sv
// Seeded 16-bit Galois LFSR with advance enable; exposes the low OutW bits.
module lfsr16
    import mac_tx_retry_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = DefLfsrSeed,
    parameter int unsigned OutW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    output logic [OutW-1:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    // Shift right and fold the feedback taps in when the outgoing bit is set.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? Lfsr16Taps : 16'h0000);
        end
    end

    // State register; seed must be nonzero so the sequence never locks up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[OutW-1:0];

endmodule

// File: rtl/mac_tx_retry_ctrl.sv
// Half-duplex transmit retry controller: jam, truncated binary exponential backoff and
// replay sequencing around the transmit replay buffer.
module mac_tx_retry_ctrl
    import mac_tx_retry_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS  = DefMaxAttempts,
    parameter int unsigned BACKOFF_LIMIT = DefBackoffLimit,
    parameter int unsigned SLOT_CYCLES   = DefSlotCycles,
    parameter int unsigned JAM_CYCLES    = DefJamCycles,
    parameter logic [15:0] LFSR_SEED     = DefLfsrSeed,
    localparam int unsigned AttW         = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx_start,
    input  logic            tx_end,
    input  logic            collision,
    input  logic            replayable,
    output logic            replay,
    output logic            done,
    output logic            gate,
    output logic            jam,
    output logic            drop,
    output logic            late_collision,
    output logic [AttW-1:0] attempts
);

    localparam int unsigned JamW = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES) : 1;
    localparam int unsigned CycW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned SlotW = BACKOFF_LIMIT;

    localparam logic [AttW-1:0]  AttMax  = AttW'(MAX_ATTEMPTS);
    localparam logic [JamW-1:0]  JamLast = JamW'(JAM_CYCLES - 1);
    localparam logic [CycW-1:0]  CycLast = CycW'(SLOT_CYCLES - 1);
    localparam logic [SlotW-1:0] SlotOne = SlotW'(1);

    tx_state_e        state_q, state_d;
    logic [AttW-1:0]  attempts_q, attempts_d;
    logic             abort_q, abort_d;
    logic [JamW-1:0]  jam_cnt_q, jam_cnt_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [CycW-1:0]  cyc_q, cyc_d;

    logic replay_q, replay_d;
    logic done_q, done_d;
    logic gate_q, gate_d;
    logic jam_q, jam_d;
    logic drop_q, drop_d;
    logic late_q, late_d;

    logic [SlotW-1:0] lfsr_low;
    logic [SlotW-1:0] bo_mask;
    logic [SlotW-1:0] bo_r;
    logic             jam_last;
    logic             bo_last;
    logic             can_retry;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .OutW (SlotW)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .lfsr_o (lfsr_low)
    );

    // Backoff mask keeps k = min(attempts, BACKOFF_LIMIT) low bits of the LFSR.
    always_comb begin
        bo_mask = '0;
        for (int i = 0; i < int'(SlotW); i++) begin
            bo_mask[i] = (int'(attempts_q) > i);
        end
    end

    assign bo_r      = lfsr_low & bo_mask;
    assign jam_last  = (state_q == StJam) && (jam_cnt_q == JamLast);
    // r == 0 still spends one cycle in backoff; otherwise exit after r full slots.
    assign bo_last   = (slot_q == '0) || ((slot_q == SlotOne) && (cyc_q == CycLast));
    assign can_retry = !abort_q && (attempts_q != AttMax);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            attempts_q <= '0;
            abort_q    <= 1'b0;
            jam_cnt_q  <= '0;
            slot_q     <= '0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            attempts_q <= attempts_d;
            abort_q    <= abort_d;
            jam_cnt_q  <= jam_cnt_d;
            slot_q     <= slot_d;
            cyc_q      <= cyc_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        abort_d    = abort_q;
        jam_cnt_d  = jam_cnt_q;
        slot_d     = slot_q;
        cyc_d      = cyc_q;
        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    state_d    = StXmit;
                    attempts_d = '0;
                end
            end
            StXmit: begin
                // Collision wins over a coincident tx_end.
                if (collision) begin
                    state_d   = StJam;
                    jam_cnt_d = '0;
                    if (replayable) begin
                        abort_d = 1'b0;
                        if (attempts_q != AttMax) begin
                            attempts_d = attempts_q + AttW'(1);
                        end
                    end else begin
                        abort_d = 1'b1;
                    end
                end else if (tx_end) begin
                    state_d = StIdle;
                end
            end
            StJam: begin
                jam_cnt_d = jam_cnt_q + JamW'(1);
                if (jam_last) begin
                    if (can_retry && replayable) begin
                        state_d = StBackoff;
                        slot_d  = bo_r;
                        cyc_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StBackoff: begin
                if (bo_last) begin
                    state_d = StXmit;
                end else if (cyc_q == CycLast) begin
                    cyc_d  = '0;
                    slot_d = slot_q - SlotOne;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; pulses come from the transition being taken.
    always_comb begin
        replay_d = 1'b0;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        late_d   = 1'b0;
        unique case (state_q)
            StXmit: begin
                if (collision) begin
                    late_d = !replayable;
                end else if (tx_end) begin
                    done_d = 1'b1;
                end
            end
            StJam: begin
                if (jam_last) begin
                    if (!can_retry) begin
                        drop_d = 1'b1;
                        done_d = 1'b1;
                    end else if (!replayable) begin
                        late_d = 1'b1;
                        drop_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        replay_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        gate_d = (state_d == StJam) || (state_d == StBackoff);
        jam_d  = (state_d == StJam);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            replay_q <= 1'b0;
            done_q   <= 1'b0;
            gate_q   <= 1'b0;
            jam_q    <= 1'b0;
            drop_q   <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            replay_q <= replay_d;
            done_q   <= done_d;
            gate_q   <= gate_d;
            jam_q    <= jam_d;
            drop_q   <= drop_d;
            late_q   <= late_d;
        end
    end

    assign replay         = replay_q;
    assign done           = done_q;
    assign gate           = gate_q;
    assign jam            = jam_q;
    assign drop           = drop_q;
    assign late_collision = late_q;
    assign attempts       = attempts_q;

endmodule

// File: tb/tb_mac_tx_retry_ctrl.sv
// Self-checking bench for mac_tx_retry_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized packets.
module tb_mac_tx_retry_ctrl;

    localparam int          MaxAtt = 16;
    localparam int          BoLim  = 10;
    localparam int          Slot   = 2;
    localparam int          JamLen = 32;
    localparam logic [15:0] Seed   = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic       tx_end = 1'b0;
    logic       collision = 1'b0;
    logic       replayable = 1'b1;
    logic       replay, done, gate, jam, drop, late_collision;
    logic [4:0] attempts;

    mac_tx_retry_ctrl #(
        .MAX_ATTEMPTS  (MaxAtt),
        .BACKOFF_LIMIT (BoLim),
        .SLOT_CYCLES   (Slot),
        .JAM_CYCLES    (JamLen),
        .LFSR_SEED     (Seed)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_start       (tx_start),
        .tx_end         (tx_end),
        .collision      (collision),
        .replayable     (replayable),
        .replay         (replay),
        .done           (done),
        .gate           (gate),
        .jam            (jam),
        .drop           (drop),
        .late_collision (late_collision),
        .attempts       (attempts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {MIdle, MXmit, MJam, MBack} mmode_e;
    mmode_e      m_mode = MIdle;
    int          m_att = 0;
    bit          m_abort = 1'b0;
    int          m_left = 0;      // cycles still to spend in the current jam/backoff phase
    logic [15:0] m_lfsr = Seed;   // LFSR value during the current cycle
    int          m_r = 0;
    bit          e_replay, e_done, e_drop, e_late;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        logic [15:0] cur;
        int k;
        e_replay = 1'b0;
        e_done   = 1'b0;
        e_drop   = 1'b0;
        e_late   = 1'b0;
        if (rst) begin
            m_mode  = MIdle;
            m_att   = 0;
            m_abort = 1'b0;
            m_left  = 0;
            m_lfsr  = Seed;
        end else begin
            cur    = m_lfsr;
            m_lfsr = lstep(cur);
            case (m_mode)
                MIdle: if (tx_start) begin
                    m_mode = MXmit;
                    m_att  = 0;
                end
                MXmit: begin
                    if (collision) begin
                        if (replayable) begin
                            m_att   = (m_att < MaxAtt) ? m_att + 1 : MaxAtt;
                            m_abort = 1'b0;
                        end else begin
                            e_late  = 1'b1;
                            m_abort = 1'b1;
                        end
                        m_mode = MJam;
                        m_left = JamLen;
                    end else if (tx_end) begin
                        e_done = 1'b1;
                        m_mode = MIdle;
                    end
                end
                MJam: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_abort || m_att == MaxAtt) begin
                            e_drop = 1'b1;
                            e_done = 1'b1;
                            m_mode = MIdle;
                        end else if (!replayable) begin
                            e_late = 1'b1;
                            e_drop = 1'b1;
                            e_done = 1'b1;
                            m_mode = MIdle;
                        end else begin
                            e_replay = 1'b1;
                            k        = (m_att < BoLim) ? m_att : BoLim;
                            m_r      = int'(cur) & ((1 << k) - 1);
                            m_left   = (m_r == 0) ? 1 : m_r * Slot;
                            m_mode   = MBack;
                        end
                    end
                end
                MBack: begin
                    m_left--;
                    if (m_left == 0) m_mode = MXmit;
                end
                default: m_mode = MIdle;
            endcase
        end
        #1;
        chk("m_replay", replay, e_replay);
        chk("m_done", done, e_done);
        chk("m_drop", drop, e_drop);
        chk("m_late", late_collision, e_late);
        chk("m_gate", gate, (m_mode == MJam || m_mode == MBack));
        chk("m_jam", jam, (m_mode == MJam));
        chk("m_attempts", attempts, m_att);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        tx_start  = 1'b0;
        tx_end    = 1'b0;
        collision = 1'b0;
    endtask

    task automatic wait_mode(input mmode_e m, input int budget, input string nm);
        int n;
        n = 0;
        while (m_mode != m && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, int'(m_mode), int'(m));
    endtask

    task automatic start_pkt();
        tx_start = 1'b1;
        cyc();
        clr();
    endtask

    // Counts gate-high cycles from now; reports jam cycles and replay pulses seen.
    task automatic measure_gate(output int gate_n, output int jam_n, output int rep_n);
        gate_n = 0;
        jam_n  = 0;
        rep_n  = 0;
        while (gate === 1'b1 && gate_n < 5000) begin
            gate_n++;
            if (jam === 1'b1) jam_n++;
            if (replay === 1'b1) rep_n++;
            cyc();
        end
    endtask

    initial begin
        #400_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, j, rp, n;
        logic [15:0] v;

        clr();
        replayable = 1'b1;
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_gate", gate, 0);
        chk("rst_done", done, 0);
        chk("rst_attempts", attempts, 0);
        rst = 1'b0;
        cyc();

        // No collision: done one cycle after tx_end.
        start_pkt();
        repeat (99) cyc();
        tx_end = 1'b1;
        cyc();
        clr();
        chk("nc_done", done, 1);
        chk("nc_gate", gate, 0);
        chk("nc_attempts", attempts, 0);
        cyc();
        chk("nc_done_pulse", done, 0);

        // Single collision at XMIT cycle 20.
        start_pkt();
        repeat (19) cyc();
        collision = 1'b1;
        cyc();
        clr();
        measure_gate(g, j, rp);
        chk("sc_jam_len", j, 32);
        chk("sc_replay", rp, 1);
        chk("sc_attempts", attempts, 1);
        chk("sc_gate_len", (g == 33 || g == 34), 1);
        chk("sc_xmit_gate", gate, 0);
        tx_end = 1'b1;
        cyc();
        clr();
        chk("sc_done", done, 1);

        // r = 0: time the collision so the LFSR low bit is 0 on the final jam cycle.
        start_pkt();
        repeat (5) cyc();
        n = 0;
        forever begin
            v = m_lfsr;
            for (int i = 0; i < JamLen; i++) v = lstep(v);
            if (v[0] == 1'b0 || n > 200) break;
            cyc();
            n++;
        end
        collision = 1'b1;
        cyc();
        clr();
        measure_gate(g, j, rp);
        chk("r0_gate_len", g, 33);
        tx_end = 1'b1;
        cyc();
        clr();
        chk("r0_done", done, 1);

        // Excessive collisions: the 16th jam ends with drop+done and no replay.
        start_pkt();
        for (int a = 1; a <= MaxAtt; a++) begin
            wait_mode(MXmit, 40000, "ex_wait_xmit");
            repeat (3) cyc();
            collision = 1'b1;
            cyc();
            clr();
            chk("ex_attempts", attempts, a);
        end
        n = 0;
        while (jam === 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        chk("ex_drop", drop, 1);
        chk("ex_done", done, 1);
        chk("ex_no_replay", replay, 0);
        chk("ex_attempts_final", attempts, 16);

        // Late collision.
        start_pkt();
        repeat (10) cyc();
        replayable = 1'b0;
        collision  = 1'b1;
        cyc();
        clr();
        chk("lc_late", late_collision, 1);
        chk("lc_jam", jam, 1);
        chk("lc_attempts", attempts, 0);
        measure_gate(g, j, rp);
        chk("lc_jam_len", j, 32);
        chk("lc_drop", drop, 1);
        chk("lc_done", done, 1);
        chk("lc_replay", rp + int'(replay), 0);
        replayable = 1'b1;
        cyc();

        // Asynchronous reset mid-backoff.
        start_pkt();
        repeat (4) cyc();
        collision = 1'b1;
        cyc();
        clr();
        wait_mode(MBack, 100, "ar_wait_back");
        #1 rst = 1'b1;
        #1;
        chk("ar_gate", gate, 0);
        chk("ar_jam", jam, 0);
        chk("ar_attempts", attempts, 0);
        chk("ar_pulses", {replay, done, drop, late_collision}, 0);
        cyc();
        rst = 1'b0;
        cyc();
        start_pkt();
        chk("ar_fresh_attempts", attempts, 0);
        chk("ar_fresh_gate", gate, 0);
        repeat (3) cyc();
        collision = 1'b1;
        tx_end    = 1'b1;
        cyc();
        clr();
        chk("ce_jam", jam, 1);
        chk("ce_no_done", done, 0);
        chk("ce_attempts", attempts, 1);
        wait_mode(MXmit, 5000, "ce_wait_xmit");
        tx_end = 1'b1;
        cyc();
        clr();
        chk("ce_done", done, 1);

        // Randomized packets; the per-cycle model comparison does the checking.
        for (int p = 0; p < 40; p++) begin
            repeat ($urandom_range(0, 5)) begin
                collision = ($urandom_range(0, 9) == 0);
                tx_end    = ($urandom_range(0, 9) == 0);
                cyc();
            end
            clr();
            start_pkt();
            n = 0;
            while (m_mode != MIdle && n < 50000) begin
                tx_start  = ($urandom_range(0, 99) < 5);
                collision = ($urandom_range(0, 99) < 6);
                tx_end    = ($urandom_range(0, 99) < 3);
                if (m_mode == MXmit) replayable = ($urandom_range(0, 99) >= 3);
                else replayable = ($urandom_range(0, 99) >= 2);
                cyc();
                n++;
            end
            clr();
            replayable = 1'b1;
            chk("rnd_pkt_end", int'(m_mode), int'(MIdle));
        end

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
